scancode_stim: RTL and testbench

Parametrised scancode stimulus generator for bring-up of the keyboard path. It emits a programmable sequence of codes (increment, decrement, LFSR or fixed) as single-cycle strobes at a configurable clock interval. Its outputs drive the `scancode`/`strobe_in` inputs of `scancode_convert`. It supersedes the hard-wired free-running counter in the board top levels, and adds burst length, start/stop control and sink back-pressure.

---
 rtl/scancode_stim.sv | 160 ++++++++++++++++
 tb/tb_scancode_stim.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scancode_stim.sv
// Scancode stimulus generator: programmable code sequences as single-cycle strobes for keyboard-path bring-up.
// Define SCANCODE_STIM_BREAK_EN to emit each key as make / BREAK_CODE / make.
module scancode_stim #(
  parameter int          WIDTH      = 8,
  parameter int          CNT_W      = 16,
  parameter int          DIV_W      = 8,
  parameter logic [31:0] TAPS       = 32'h0000_00B8,
  parameter logic [31:0] BREAK_CODE = 32'h0000_00F0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] count,
  input  logic [DIV_W-1:0] interval,
  input  logic             sink_busy,
  output logic [WIDTH-1:0] code,
  output logic             strobe,
  output logic             brk,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [WIDTH-1:0] L_TAPS = WIDTH'(TAPS);

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_next;
  logic [CNT_W-1:0] r_remaining;
  logic             r_freeRun;
  logic [DIV_W-1:0] r_ival;
  logic [DIV_W-1:0] r_tick;

  logic [DIV_W-1:0] w_interval;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_advance;
  logic             w_lastByte;

  assign w_interval = (interval == '0) ? DIV_W'(1) : interval;
  assign w_seed     = (mode == 2'd2 && seed == '0) ? WIDTH'(1) : seed;

  always_comb begin
    w_advance = r_next;
    case (r_mode)
      2'd0:    w_advance = r_next + WIDTH'(1);
      2'd1:    w_advance = r_next - WIDTH'(1);
      2'd2:    w_advance = {1'b0, r_next[WIDTH-1:1]} ^ (r_next[0] ? L_TAPS : '0);
      default: w_advance = r_next;
    endcase
  end

`ifdef SCANCODE_STIM_BREAK_EN
  localparam logic [WIDTH-1:0] L_BREAK = WIDTH'(BREAK_CODE);

  // r_phase selects make, break prefix, or repeated make within one key
  logic [1:0] r_phase;

  assign w_lastByte = (r_phase == 2'd2);
`else
  logic w_unused;

  assign w_unused   = ^BREAK_CODE;
  assign w_lastByte = 1'b1;
  assign brk        = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_next      <= '0;
      r_remaining <= '0;
      r_freeRun   <= 1'b0;
      r_ival      <= '0;
      r_tick      <= '0;
      code        <= '0;
      strobe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SCANCODE_STIM_BREAK_EN
      r_phase     <= '0;
      brk         <= 1'b0;
`endif
    end else begin
      strobe <= 1'b0;
      done   <= 1'b0;
`ifdef SCANCODE_STIM_BREAK_EN
      brk    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !stop) begin
            r_mode      <= mode;
            r_next      <= w_seed;
            r_remaining <= count;
            r_freeRun   <= (count == '0);
            r_ival      <= w_interval;
            r_tick      <= w_interval;
            busy        <= 1'b1;
            r_state     <= S_WAIT;
`ifdef SCANCODE_STIM_BREAK_EN
            r_phase     <= '0;
`endif
          end
        end
        S_WAIT: begin
          // stop wins over an emission due on the same edge
          if (stop) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tick > DIV_W'(1)) begin
            r_tick <= r_tick - DIV_W'(1);
          end else if (!sink_busy) begin
            strobe <= 1'b1;
            r_tick <= r_ival;
`ifdef SCANCODE_STIM_BREAK_EN
            case (r_phase)
              2'd0: begin
                code    <= r_next;
                r_phase <= 2'd1;
              end
              2'd1: begin
                code    <= L_BREAK;
                brk     <= 1'b1;
                r_phase <= 2'd2;
              end
              default: begin
                code    <= r_next;
                r_phase <= 2'd0;
              end
            endcase
`else
            code   <= r_next;
`endif
            if (w_lastByte) begin
              r_next <= w_advance;
              if (!r_freeRun) begin
                r_remaining <= r_remaining - CNT_W'(1);
                if (r_remaining == CNT_W'(1)) begin
                  r_state <= S_DONE;
                end
              end
            end
          end
        end
        default: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scancode_stim.sv
// Self-checking bench for scancode_stim: expected strobes and done pulses are queued per scenario and
// consumed by a monitor as the design emits them.
module tb_scancode_stim;

  typedef struct {
    int         edgeNo;
    logic [7:0] code;
    logic       brk;
  } strobeExp_t;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [15:0] count;
  logic [7:0] interval;
  logic       sink_busy;
  logic [7:0] code;
  logic       strobe;
  logic       brk;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int edgeCnt = 0;

  strobeExp_t expStrobe[$];
  int         expDone[$];

  scancode_stim dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .seed      (seed),
    .count     (count),
    .interval  (interval),
    .sink_busy (sink_busy),
    .code      (code),
    .strobe    (strobe),
    .brk       (brk),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  // Scoreboard monitor: every strobe and done pulse must match the head of its queue
  always @(negedge clock) begin : monitor
    strobeExp_t e;
    int         d;
    if (!reset) begin
      if (strobe) begin
        checks++;
        if (expStrobe.size() == 0) begin
          errors++;
          $display("[TB] FAIL strobe_unexpected: got strobe at edge %0d code %h, expected none", edgeCnt, code);
        end else begin
          e = expStrobe.pop_front();
          if (edgeCnt !== e.edgeNo || code !== e.code || brk !== e.brk) begin
            errors++;
            $display("[TB] FAIL strobe_match: got edge %0d code %h brk %b, expected edge %0d code %h brk %b",
                     edgeCnt, code, brk, e.edgeNo, e.code, e.brk);
          end
        end
      end
      if (done) begin
        checks++;
        if (expDone.size() == 0) begin
          errors++;
          $display("[TB] FAIL done_unexpected: got done at edge %0d, expected none", edgeCnt);
        end else begin
          d = expDone.pop_front();
          if (edgeCnt !== d) begin
            errors++;
            $display("[TB] FAIL done_edge: got done at edge %0d, expected edge %0d", edgeCnt, d);
          end
        end
      end
    end
  end

  task automatic pushStrobe(input int edgeNo, input logic [7:0] c, input logic b);
    strobeExp_t e;
    e.edgeNo = edgeNo;
    e.code   = c;
    e.brk    = b;
    expStrobe.push_back(e);
  endtask

  task automatic waitEdge(input int target);
    while (edgeCnt < target) @(negedge clock);
  endtask

  task automatic doStart(input logic [1:0] m, input logic [7:0] s, input logic [15:0] c,
                         input logic [7:0] iv, output int k);
    @(negedge clock);
    mode     = m;
    seed     = s;
    count    = c;
    interval = iv;
    start    = 1'b1;
    k        = edgeCnt + 1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((expStrobe.size() != 0 || expDone.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (expStrobe.size() != 0 || expDone.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d strobes and %0d dones outstanding, expected 0",
               name, expStrobe.size(), expDone.size());
      expStrobe.delete();
      expDone.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({code, strobe, brk, busy, done} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected 000", {code, strobe, brk, busy, done});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || strobe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy %b strobe %b, expected 0 0", busy, strobe);
    end
  endtask

  task automatic test_increment();
    int k;
    doStart(2'd0, 8'hFE, 16'd3, 8'd8, k);
    pushStrobe(k + 8, 8'hFE, 1'b0);
    pushStrobe(k + 16, 8'hFF, 1'b0);
    pushStrobe(k + 24, 8'h00, 1'b0);
    expDone.push_back(k + 25);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inc_busy_start: got %b, expected 1", busy);
    end
    waitEdge(k + 12);
    checks++;
    if (code !== 8'hFE) begin
      errors++;
      $display("[TB] FAIL inc_code_hold: got %h, expected fe", code);
    end
    waitEdge(k + 24);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inc_busy_last: got %b, expected 1", busy);
    end
    waitEdge(k + 25);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inc_busy_done: got %b, expected 0", busy);
    end
    waitDrain("increment", 50);
  endtask

  task automatic test_lfsr();
    int k;
    doStart(2'd2, 8'h00, 16'd4, 8'd1, k);
    pushStrobe(k + 1, 8'h01, 1'b0);
    pushStrobe(k + 2, 8'hB8, 1'b0);
    pushStrobe(k + 3, 8'h5C, 1'b0);
    pushStrobe(k + 4, 8'h2E, 1'b0);
    expDone.push_back(k + 5);
    waitDrain("lfsr", 50);
  endtask

  task automatic test_decrement();
    int k;
    doStart(2'd1, 8'h01, 16'd3, 8'd0, k);
    pushStrobe(k + 1, 8'h01, 1'b0);
    pushStrobe(k + 2, 8'h00, 1'b0);
    pushStrobe(k + 3, 8'hFF, 1'b0);
    expDone.push_back(k + 4);
    waitDrain("decrement", 50);
  endtask

  task automatic test_backpressure();
    int k;
    doStart(2'd3, 8'h1C, 16'd2, 8'd4, k);
    pushStrobe(k + 10, 8'h1C, 1'b0);
    pushStrobe(k + 14, 8'h1C, 1'b0);
    expDone.push_back(k + 15);
    waitEdge(k + 3);
    sink_busy = 1'b1;
    waitEdge(k + 9);
    sink_busy = 1'b0;
    waitDrain("backpressure", 50);
  endtask

  task automatic test_abort();
    int k;
    int k2;
    doStart(2'd0, 8'h10, 16'd0, 8'd3, k);
    pushStrobe(k + 3, 8'h10, 1'b0);
    pushStrobe(k + 6, 8'h11, 1'b0);
    waitEdge(k + 8);
    stop  = 1'b1;
    start = 1'b1;
    waitEdge(k + 9);
    checks++;
    if (strobe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_stop: got strobe %b busy %b, expected 0 0", strobe, busy);
    end
    waitEdge(k + 10);
    stop  = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_start_ignored: got busy %b, expected 0", busy);
    end
    repeat (12) @(negedge clock);
    checks++;
    if (expStrobe.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got %0d pending strobes busy %b, expected 0 0", expStrobe.size(), busy);
    end
    doStart(2'd3, 8'h5A, 16'd1, 8'd2, k2);
    pushStrobe(k2 + 2, 8'h5A, 1'b0);
    expDone.push_back(k2 + 3);
    waitDrain("restart", 50);
  endtask

  task automatic test_reset_mid();
    int k;
    doStart(2'd0, 8'h40, 16'd0, 8'd5, k);
    pushStrobe(k + 5, 8'h40, 1'b0);
    waitEdge(k + 7);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({code, strobe, brk, busy, done} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got %h, expected 000", {code, strobe, brk, busy, done});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || expStrobe.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet: got busy %b pending %0d, expected 0 0", busy, expStrobe.size());
    end
  endtask

  task automatic test_break();
    int k;
    doStart(2'd3, 8'h1C, 16'd1, 8'd2, k);
    pushStrobe(k + 2, 8'h1C, 1'b0);
    pushStrobe(k + 4, 8'hF0, 1'b1);
    pushStrobe(k + 6, 8'h1C, 1'b0);
    expDone.push_back(k + 7);
    waitDrain("break", 50);
  endtask

  initial begin
    start     = 1'b0;
    stop      = 1'b0;
    mode      = 2'd0;
    seed      = 8'h00;
    count     = 16'd0;
    interval  = 8'd0;
    sink_busy = 1'b0;
    test_reset();
`ifdef SCANCODE_STIM_BREAK_EN
    test_break();
    test_reset_mid();
`else
    test_increment();
    test_lfsr();
    test_decrement();
    test_backpressure();
    test_abort();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
